// File: rtl/imem_responder_if.sv
// Fetch-side bus for imem_responder: request, response and program-load channels.
interface imem_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        rsp_ready;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with registered read into a 2-entry response FIFO.
// Define IMEM_ADDR_CHECK_EN to flag misaligned/out-of-range fetches and drop out-of-range loads.
module imem_responder #(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  imem_responder_if.slave io_bus
);
  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  logic [31:0]   r_mem       [DEPTH_WORDS];
  logic [31:0]   r_fifo_inst [2];
  logic [31:0]   r_fifo_addr [2];
  logic          r_fifo_err  [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_occ;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_ld_idx;
  logic          w_rd_err;
  logic          w_ld_ok;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  assign w_rd_idx = io_bus.req_addr[AW+1:2];
  assign w_ld_idx = io_bus.ld_addr[AW+1:2];

`ifdef IMEM_ADDR_CHECK_EN
  assign w_rd_err = (io_bus.req_addr[1:0] != 2'b00) ||
                    ({2'b00, io_bus.req_addr[31:2]} >= DEPTH32);
  assign w_ld_ok  = ({2'b00, io_bus.ld_addr[31:2]} < DEPTH32);
`else
  assign w_rd_err = 1'b0;
  assign w_ld_ok  = 1'b1;
`endif

  assign w_unused = ^{io_bus.req_addr[31:AW+2], io_bus.req_addr[1:0],
                      io_bus.ld_addr[31:AW+2], io_bus.ld_addr[1:0]};

  assign w_rd_data = w_rd_err ? 32'h0000_0000 : r_mem[w_rd_idx];

  // The FIFO slot written on acceptance is the registered read itself,
  // so a response appears the cycle after its request is taken.
  assign w_pop  = (r_occ != 2'd0) && io_bus.rsp_ready;
  assign io_bus.req_ready = rst && ((r_occ - {1'b0, w_pop}) < 2'd2);
  assign w_push = io_bus.req_valid && io_bus.req_ready;

  assign io_bus.rsp_valid = (r_occ != 2'd0);
  assign io_bus.rsp_inst  = r_fifo_inst[r_rptr];
  assign io_bus.rsp_addr  = r_fifo_addr[r_rptr];
  assign io_bus.rsp_err   = r_fifo_err[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_wptr] <= w_rd_data;
      r_fifo_addr[r_wptr] <= io_bus.req_addr;
      r_fifo_err[r_wptr]  <= w_rd_err;
    end
  end

  // Memory is outside the reset domain so a program survives reset.
  always_ff @(posedge clk) begin
    if (io_bus.ld_en && w_ld_ok) r_mem[w_ld_idx] <= io_bus.ld_data;
  end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder against a queue-based reference model.
module tb_imem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;

  imem_responder_if bus ();

  imem_responder #(.DEPTH_WORDS(256), .INIT_FILE("")) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  logic [31:0] mdl_mem [256];
  rsp_t        q[$];
  int          total = 0;
  int          bad = 0;

  function automatic bit ld_in_range(input logic [31:0] a);
`ifdef IMEM_ADDR_CHECK_EN
    return (a / 4) < 256;
`else
    return 1'b1;
`endif
  endfunction

  function automatic rsp_t mdl_read(input logic [31:0] a);
    rsp_t r;
    r.addr = a;
`ifdef IMEM_ADDR_CHECK_EN
    r.err  = ((a % 4) != 0) || ((a / 4) >= 256);
    r.inst = r.err ? 32'h0 : mdl_mem[(a / 4) % 256];
`else
    r.err  = 1'b0;
    r.inst = mdl_mem[(a / 4) % 256];
`endif
    return r;
  endfunction

  task automatic drive(input bit rv, input logic [31:0] ra, input bit rr,
                       input bit le, input logic [31:0] la, input logic [31:0] ldat);
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.rsp_ready = rr;
    bus.ld_en     = le;
    bus.ld_addr   = la;
    bus.ld_data   = ldat;
  endtask

  // Advance the reference model by one clock edge, then move to just after it.
  task automatic tick();
    bit   pop;
    bit   acc;
    rsp_t r;
    pop = (q.size() > 0) && (bus.rsp_ready === 1'b1);
    acc = (rst === 1'b1) && (bus.req_valid === 1'b1) && ((q.size() - int'(pop)) < 2);
    if (rst !== 1'b1) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        r = mdl_read(bus.req_addr);
        q.push_back(r);
      end
    end
    if (bus.ld_en === 1'b1 && ld_in_range(bus.ld_addr))
      mdl_mem[(bus.ld_addr / 4) % 256] = bus.ld_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
      end
      total++;
      if (bus.req_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_req_ready got=%b exp=0", bus.req_ready);
      end
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL release_req_ready got=%b exp=1", bus.req_ready);
    end
    tick();
  endtask

  task automatic test_preload();
    logic [31:0] last;
    last = 32'h0;
    for (int i = 0; i < 256; i++) begin
      last = $urandom();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), last);
      tick();
    end
    drive(1'b1, 32'h3FC, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== last) begin
      bad++; $display("[TB] FAIL preload_readback got=%h exp=%h", bus.rsp_inst, last);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 32'h20080001 + 32'(i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, 32'(i * 4), 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== (i > 0)) begin
        bad++; $display("[TB] FAIL stream_valid[%0d] got=%b exp=%b", i, bus.rsp_valid, i > 0);
      end
      if (i > 0) begin
        exp = 32'h20080000 + 32'(i);
        total++;
        if (bus.rsp_inst !== exp) begin
          bad++; $display("[TB] FAIL stream_inst[%0d] got=%h exp=%h", i, bus.rsp_inst, exp);
        end
        total++;
        if (bus.rsp_addr !== 32'((i - 1) * 4)) begin
          bad++; $display("[TB] FAIL stream_addr[%0d] got=%h exp=%h", i, bus.rsp_addr, (i - 1) * 4);
        end
      end
      total++;
      if (bus.req_ready !== 1'b1) begin
        bad++; $display("[TB] FAIL stream_ready[%0d] got=%b exp=1", i, bus.req_ready);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w8, w9, w10;
    bit          rv [8]  = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] ra [8]  = '{32'h20, 32'h24, 32'h28, 32'h28, 32'h28, 0, 0, 0};
    bit          rr [8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    bit          erdy [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    bit          evld [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] einst [8];
    logic [31:0] eaddr [8];
    w8 = mdl_mem[8]; w9 = mdl_mem[9]; w10 = mdl_mem[10];
    einst = '{0, w8, w8, w8, w8, w9, w10, 0};
    eaddr = '{0, 32'h20, 32'h20, 32'h20, 32'h20, 32'h24, 32'h28, 0};
    for (int i = 0; i < 8; i++) begin
      drive(rv[i], ra[i], rr[i], 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      total++;
      if (bus.req_ready !== erdy[i]) begin
        bad++; $display("[TB] FAIL bp_ready[%0d] got=%b exp=%b", i, bus.req_ready, erdy[i]);
      end
      total++;
      if (bus.rsp_valid !== evld[i]) begin
        bad++; $display("[TB] FAIL bp_valid[%0d] got=%b exp=%b", i, bus.rsp_valid, evld[i]);
      end
      if (evld[i]) begin
        total++;
        if (bus.rsp_inst !== einst[i] || bus.rsp_addr !== eaddr[i]) begin
          bad++; $display("[TB] FAIL bp_data[%0d] got=%h/%h exp=%h/%h", i,
                          bus.rsp_inst, bus.rsp_addr, einst[i], eaddr[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_read_before_write();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h12345678);
    tick();
    drive(1'b1, 32'h14, 1'b1, 1'b1, 32'h14, 32'hDEADBEEF);
    tick();
    drive(1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== 32'h12345678) begin
      bad++; $display("[TB] FAIL rbw_old got=%h exp=12345678", bus.rsp_inst);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL rbw_new got=%h exp=deadbeef", bus.rsp_inst);
    end
    tick();
  endtask

  task automatic test_addr_check();
    logic [31:0] addrs [2] = '{32'h402, 32'h400};
`ifdef IMEM_ADDR_CHECK_EN
    logic [31:0] einst = 32'h0;
    logic        eerr  = 1'b1;
`else
    logic [31:0] einst = 32'h20080001;
    logic        eerr  = 1'b0;
`endif
    drive(1'b1, addrs[0], 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(i == 0, addrs[1], 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== eerr || bus.rsp_inst !== einst ||
          bus.rsp_addr !== addrs[i]) begin
        bad++; $display("[TB] FAIL addr_check[%0d] got=%b/%h/%h exp=%b/%h/%h", i,
                        bus.rsp_err, bus.rsp_inst, bus.rsp_addr, eerr, einst, addrs[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL midrst_ready[%0d] got=%b exp=0", i, bus.req_ready);
      end
      if (i > 0) begin
        total++;
        if (bus.rsp_valid !== 1'b0) begin
          bad++; $display("[TB] FAIL midrst_valid[%0d] got=%b exp=0", i, bus.rsp_valid);
        end
      end
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL midrst_release got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== 32'h20080003 || bus.rsp_addr !== 32'h8) begin
      bad++; $display("[TB] FAIL midrst_first got=%b/%h/%h exp=1/20080003/8",
                      bus.rsp_valid, bus.rsp_inst, bus.rsp_addr);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] la;
    bit          pexp;
    bit          erdy;
    for (int c = 0; c < 10000; c++) begin
      ra = 32'($urandom_range(0, 1151));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      la = 32'($urandom_range(0, 1151));
      drive(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), la, $urandom());
      @(negedge clk);
      pexp = (q.size() > 0) && bus.rsp_ready;
      erdy = (q.size() - int'(pexp)) < 2;
      total++;
      if (bus.req_ready !== erdy) begin
        bad++; $display("[TB] FAIL rand_ready[%0d] got=%b exp=%b", c, bus.req_ready, erdy);
      end
      total++;
      if (bus.rsp_valid !== (q.size() > 0)) begin
        bad++; $display("[TB] FAIL rand_valid[%0d] got=%b exp=%b", c, bus.rsp_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        total++;
        if (bus.rsp_inst !== q[0].inst || bus.rsp_addr !== q[0].addr || bus.rsp_err !== q[0].err) begin
          bad++; $display("[TB] FAIL rand_rsp[%0d] got=%h/%h/%b exp=%h/%h/%b", c,
                          bus.rsp_inst, bus.rsp_addr, bus.rsp_err, q[0].inst, q[0].addr, q[0].err);
        end
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL rand_drain got=%b exp=0", bus.rsp_valid);
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_preload();
    test_stream();
    test_back_to_back();
    test_read_before_write();
    test_addr_check();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: instruction memory depth in 32-bit words; SHALL be a power of two and at least 4.
REQ-002 Parameter INIT_FILE, default "": hex image loaded at elaboration; an empty string SHALL leave the contents undefined.
REQ-003 Port clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1: synchronous, active-low reset.
REQ-005 Port req_valid  in  1: the fetch stage presents a read request.
REQ-006 Port req_addr  in  32: the byte address (PC) of the request.
REQ-007 Port req_ready  out  1: the block can accept a request this cycle.
REQ-008 Port rsp_valid  out  1: the head response is valid.
REQ-009 Port rsp_inst  out  32: the instruction word of the head response.
REQ-010 Port rsp_addr  out  32: req_addr echoed for the head response.
REQ-011 Port rsp_err  out  1: error flag for the head response (see Configuration).
REQ-012 Port rsp_ready  in  1: the fetch stage consumes the head response.
REQ-013 Port ld_en  in  1: program-load write strobe.
REQ-014 Port ld_addr  in  32: program-load byte address.
REQ-015 Port ld_data  in  32: program-load data word.

Function
REQ-016 A request SHALL be accepted on a cycle where req_valid=1 and req_ready=1.
REQ-017 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored unless IMEM_ADDR_CHECK_EN is defined.
REQ-018 The memory read SHALL be registered into a single in-flight stage, so an accepted request is visible on rsp_* no earlier than the next cycle.
REQ-019 Responses SHALL pass through a 2-entry FIFO, head first, in request order; no response SHALL be dropped or reordered.
REQ-020 rsp_valid SHALL be 1 exactly when FIFO occupancy > 0; rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-021 A pop SHALL occur on a cycle where rsp_valid=1 and rsp_ready=1.
REQ-022 req_ready SHALL equal (occupancy + inflight - pop) < 2; this is a permitted combinational path from rsp_ready.
REQ-023 With req_valid and rsp_ready both held at 1, the block SHALL sustain one request and one response per cycle.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged, including at occupancy 2.
REQ-025 ld_en=1 SHALL write ld_data to word ld_addr[log2(DEPTH_WORDS)+1:2] at the clock edge.
REQ-026 A load and an accepted read of the same word in the same cycle SHALL return the old data (read-before-write).
REQ-027 FIFO pointers SHALL wrap modulo 2.

Reset
REQ-028 On a clock edge with rst=0, the block SHALL clear occupancy, inflight and the pointers, and drive rsp_valid=0.
REQ-029 While rst=0, req_ready SHALL be 0.
REQ-030 Reset SHALL discard any in-flight request or buffered response, including one arriving mid-transfer.
REQ-031 Memory contents SHALL NOT be altered by reset.
REQ-032 The first request SHALL be accepted on the first cycle after rst returns to 1.

Configuration
REQ-033 Macro IMEM_ADDR_CHECK_EN defined: rsp_err SHALL be 1 when req_addr[1:0]≠0 or req_addr[31:2] ≥ DEPTH_WORDS, and such a response SHALL carry rsp_inst=32'h00000000.
REQ-034 With IMEM_ADDR_CHECK_EN defined, an out-of-range load SHALL be ignored.
REQ-035 Macro IMEM_ADDR_CHECK_EN undefined: rsp_err SHALL be tied 0, the index SHALL wrap modulo DEPTH_WORDS, and addr[1:0] SHALL be ignored.

Verification
REQ-036 Reset held 3 cycles mid-stream, then released -> rsp_valid=0 during reset, no stale response afterwards, req_ready=1 on the first cycle after release.
REQ-037 Load words 0..3 = 0x20080001..0x20080004, then stream requests to 0x0,0x4,0x8,0xC with rsp_ready=1 -> four in-order responses on consecutive cycles, the first one cycle after acceptance.
REQ-038 rsp_ready=0 while streaming -> after two requests are held, req_ready=0; rsp_* stable; releasing rsp_ready drains both entries in order and nothing is lost.
REQ-039 Same-cycle ld_en to word 5 (0xDEADBEEF) and read of 0x14 (old value 0x12345678) -> response 0x12345678; a later read of 0x14 -> 0xDEADBEEF.
REQ-040 With IMEM_ADDR_CHECK_EN and DEPTH_WORDS=256, reads of 0x402 and 0x400 -> rsp_err=1 with rsp_inst=0 for both; without the macro, 0x400 returns word 0 with rsp_err=0.
REQ-041 Random req_valid/rsp_ready toggling for 10k cycles -> responses match a reference queue, occupancy never exceeds 2, no handshake violations.
